uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/transceiver_pkg.sv | 22 ++
 rtl/baud_gen.sv | 29 ++
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transceiver_pkg.sv
// Shared UART transceiver types and constants.
// Holds the serial FSM state encoding and line idle level.
package transceiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } xcvr_state_e;

  localparam logic LINE_IDLE = 1'b1;

  function automatic logic even_parity(
    input logic [63:0] word
  );
    return ^word;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period down-counter: tick marks the last cycle of a bit.
// Ports: clk, rst (sync high), restart (reload), tick (out).
module baud_gen #(
  parameter int BaudDiv = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(BaudDiv);
  localparam logic [CW-1:0] RELOAD = CW'(BaudDiv - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart || cnt_q == '0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0) && !restart;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops a FIFO entry and shifts it out LSB first.
// Ports: clk, rst, fifo_has_data, fifo_data, fifo_read, tx, busy.
module uart_tx
  import transceiver_pkg::*;
#(
  parameter int DataWidth    = 8,
  parameter int BaudDiv      = 434,
  parameter int ParityEnable = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_has_data,
  input  logic [DataWidth-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 busy
);

  localparam int IW = $clog2(DataWidth);
  localparam logic [IW-1:0] LAST = IW'(DataWidth - 1);

  xcvr_state_e          state_q;
  logic [DataWidth-1:0] shift_q;
  logic [IW-1:0]        idx_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 armed_q;
  logic                 tick;

  baud_gen #(
    .BaudDiv(BaudDiv)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(state_q == LOAD),
    .tick   (tick)
  );

  // armed_q holds off the first LOAD for one cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (fifo_has_data && armed_q) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          shift_q <= fifo_data;
          par_q   <= even_parity(64'(fifo_data));
          idx_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx_q == LAST) begin
              idx_q <= '0;
              if (ParityEnable != 0) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= LINE_IDLE;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= {1'b0, shift_q[DataWidth-1:1]};
              tx_q    <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            tx_q    <= LINE_IDLE;
          end
        end
        STOP: begin
          if (tick) begin
            tx_q <= LINE_IDLE;
            if (fifo_has_data) begin
              state_q <= LOAD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= LINE_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_read = (state_q == LOAD);
  assign tx        = tx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (BaudDiv=4, DataWidth=8).
// Instance dut has no parity, dut_p has even parity.
module tb_uart_tx;

  localparam int BD = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          has_data = 1'b0;
  logic [DW-1:0] data = '0;
  logic          read, tx, busy;
  logic          p_has = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic          p_read, p_tx, p_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .DataWidth(DW), .BaudDiv(BD), .ParityEnable(0)
  ) dut (
    .clk(clk), .rst(rst),
    .fifo_has_data(has_data), .fifo_data(data),
    .fifo_read(read), .tx(tx), .busy(busy)
  );

  uart_tx #(
    .DataWidth(DW), .BaudDiv(BD), .ParityEnable(1)
  ) dut_p (
    .clk(clk), .rst(rst),
    .fifo_has_data(p_has), .fifo_data(p_data),
    .fifo_read(p_read), .tx(p_tx), .busy(p_busy)
  );

  // Expected line level for frame bit b (0 = start).
  function automatic logic exp_bit(
    input logic [7:0] d, input bit par, input int b
  );
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    has_data = 1'b0;
    p_has = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bit bad;
    @(negedge clk);
    rst = 1'b1;
    has_data = 1'b1;
    data = 8'h55;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || read !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_hold: tx=%b busy=%b read=%b, need 1/0/0",
               tx, busy, read);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (read !== 1'b0) begin
      fails++;
      $display("FAIL reset_read_early: got %b need 0", read);
    end
    @(negedge clk);
    tests++;
    if (read !== 1'b1) begin
      fails++;
      $display("FAIL reset_read_2cyc: got %b need 1", read);
    end
    has_data = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    int n;
    int reads;
    bit bad;
    logic got;
    data = 8'h55;
    has_data = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (read !== 1'b1) begin
      fails++;
      $display("FAIL single_pop: read=%b need 1 within 10", read);
    end
    has_data = 1'b0;
    reads = 1;
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      got = 1'b0;
      for (int c = 0; c < BD; c++) begin
        @(negedge clk);
        if (read === 1'b1) reads++;
        if (tx !== exp_bit(8'h55, 1'b0, b) || busy !== 1'b1) begin
          bad = 1'b1;
          got = tx;
        end
      end
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL single_bit%0d: tx=%b need %b (busy=%b)",
                 b, got, exp_bit(8'h55, 1'b0, b), busy);
      end
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL single_end: busy=%b tx=%b need 0/1", busy, tx);
    end
    tests++;
    if (reads != 1) begin
      fails++;
      $display("FAIL single_reads: got %0d need 1", reads);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit bad;
    logic got;
    logic [7:0] bytes [2];
    bytes[0] = 8'h55;
    bytes[1] = 8'hA3;
    do_reset();
    data = bytes[0];
    has_data = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (read !== 1'b1) begin
      fails++;
      $display("FAIL b2b_pop: read=%b need 1", read);
    end
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 10; b++) begin
        bad = 1'b0;
        got = 1'b0;
        for (int c = 0; c < BD; c++) begin
          @(negedge clk);
          if (f == 0 && b == 0 && c == 0) data = bytes[1];
          if (tx !== exp_bit(bytes[f], 1'b0, b)) begin
            bad = 1'b1;
            got = tx;
          end
        end
        tests++;
        if (bad) begin
          fails++;
          $display("FAIL b2b_f%0d_bit%0d: tx=%b need %b",
                   f, b, got, exp_bit(bytes[f], 1'b0, b));
        end
      end
      @(negedge clk);
      if (f == 0) begin
        tests++;
        if (read !== 1'b1 || tx !== 1'b1 || busy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_gap: read=%b tx=%b busy=%b need 1/1/1",
                   read, tx, busy);
        end
        has_data = 1'b0;
      end else begin
        tests++;
        if (busy !== 1'b0 || read !== 1'b0) begin
          fails++;
          $display("FAIL b2b_end: busy=%b read=%b need 0/0",
                   busy, read);
        end
      end
    end
  endtask

  task automatic test_parity();
    int n;
    bit bad;
    logic got;
    logic [7:0] bytes [2];
    logic pbit [2];
    bytes[0] = 8'h07;
    pbit[0] = 1'b1;
    bytes[1] = 8'hA3;
    pbit[1] = 1'b0;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      p_data = bytes[f];
      p_has = 1'b1;
      n = 0;
      while (p_read !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      tests++;
      if (p_read !== 1'b1) begin
        fails++;
        $display("FAIL par_pop%0d: read=%b need 1", f, p_read);
      end
      p_has = 1'b0;
      for (int b = 0; b < 11; b++) begin
        bad = 1'b0;
        got = 1'b0;
        for (int c = 0; c < BD; c++) begin
          @(negedge clk);
          if (b == 9) begin
            if (p_tx !== pbit[f]) begin
              bad = 1'b1;
              got = p_tx;
            end
          end else if (p_tx !== exp_bit(bytes[f], 1'b1, b)) begin
            bad = 1'b1;
            got = p_tx;
          end
        end
        tests++;
        if (bad) begin
          fails++;
          $display("FAIL par_f%0d_bit%0d: tx=%b need %b", f, b, got,
                   (b == 9) ? pbit[f] : exp_bit(bytes[f], 1'b1, b));
        end
      end
      @(negedge clk);
      tests++;
      if (p_busy !== 1'b0) begin
        fails++;
        $display("FAIL par_len%0d: busy=%b after 44 need 0", f, p_busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    int reads;
    bit bad;
    logic got;
    do_reset();
    data = 8'h55;
    has_data = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (read !== 1'b1) begin
      fails++;
      $display("FAIL abort_pop: read=%b need 1", read);
    end
    has_data = 1'b0;
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || read !== 1'b0) begin
      fails++;
      $display("FAIL abort_now: tx=%b busy=%b read=%b need 1/0/0",
               tx, busy, read);
    end
    rst = 1'b0;
    reads = 0;
    repeat (20) begin
      @(negedge clk);
      if (read === 1'b1) reads++;
    end
    tests++;
    if (reads != 0) begin
      fails++;
      $display("FAIL abort_noread: got %0d need 0", reads);
    end
    data = 8'h3C;
    has_data = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (read !== 1'b1) begin
      fails++;
      $display("FAIL abort_repop: read=%b need 1", read);
    end
    has_data = 1'b0;
    bad = 1'b0;
    got = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BD; c++) begin
        @(negedge clk);
        if (tx !== exp_bit(8'h3C, 1'b0, b)) begin
          bad = 1'b1;
          got = tx;
        end
      end
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL abort_next_frame: tx=%b wrong, need byte 0x3c",
               got);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
